// File: rtl/i2s_rx_ctrl_module.sv
// I2S receiver master controller: BCK/LRCK generation, frame-aligned start/stop and a stereo FIFO.
// Define I2S_RX_CTRL_DROP_CNT_EN to add the saturating dropped-pair counter drop_cnt_o.
module i2s_rx_ctrl_module #(
    parameter int unsigned FRAME_RES  = 32,
    parameter int unsigned DATA_RES   = 24,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DIV_W-1:0]      div_i,
    output logic                  bck_o,
    output logic                  lrck_o,
    input  logic [DATA_RES-1:0]   left_i,
    input  logic [DATA_RES-1:0]   right_i,
    output logic [2*DATA_RES-1:0] tdata_o,
    output logic                  tvalid_o,
    input  logic                  tready_i,
    output logic                  ovf_o,
    input  logic                  clr_ovf_i,
`ifdef I2S_RX_CTRL_DROP_CNT_EN
    output logic [15:0]           drop_cnt_o,
`endif
    output logic                  busy_o
);

    localparam int unsigned BCW = $clog2(FRAME_RES);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam logic [BCW-1:0] BitLast = BCW'(FRAME_RES - 1);
    localparam logic [BCW-1:0] BitCap  = BCW'(2);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e state_q, state_d;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             bck_q;
    logic             lrck_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic             skip_first_q;

    logic tick, bck_fall, frame_end, strobe;

    logic [2*DATA_RES-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wptr_q, rptr_q;
    logic                  empty, full, push_req, push, pop, drop;
    logic                  ovf_q;

    assign tick      = (state_q != StIdle) && (div_cnt_q == div_q);
    assign bck_fall  = tick && bck_q;
    // Last BCK fall of the right half: LRCK returns to 0 on this edge.
    assign frame_end = bck_fall && lrck_q && (bit_cnt_q == BitLast);
    // Two BCK rises into the left half the core has just latched the previous right word.
    assign strobe    = bck_fall && !lrck_q && (bit_cnt_q == BitCap);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en_i) state_d = StRun;
            StRun:   if (!en_i) state_d = StStop;
            StStop:  if (frame_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q        <= '0;
            div_cnt_q    <= '0;
            bck_q        <= 1'b0;
            lrck_q       <= 1'b0;
            bit_cnt_q    <= '0;
            skip_first_q <= 1'b0;
        end else if (state_q == StIdle) begin
            div_cnt_q <= '0;
            bck_q     <= 1'b0;
            lrck_q    <= 1'b0;
            bit_cnt_q <= '0;
            if (en_i) begin
                div_q        <= div_i;
                skip_first_q <= 1'b1;
            end
        end else begin
            if (tick) begin
                div_cnt_q <= '0;
                bck_q     <= ~bck_q;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
            if (bck_fall) begin
                if (bit_cnt_q == BitLast) begin
                    bit_cnt_q <= '0;
                    lrck_q    <= ~lrck_q;
                end else begin
                    bit_cnt_q <= bit_cnt_q + BCW'(1);
                end
            end
            if (strobe) skip_first_q <= 1'b0;
        end
    end

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop      = !empty && tready_i;
    assign push_req = strobe && !skip_first_q;
    // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (AW + 1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= {left_i, right_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef I2S_RX_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (clr_ovf_i) begin
            drop_cnt_q <= drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign bck_o    = bck_q;
    assign lrck_o   = lrck_q;
    assign tdata_o  = mem_q[rptr_q[AW-1:0]];
    assign tvalid_o = !empty;
    assign ovf_o    = ovf_q;
    assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_i2s_rx_ctrl_module.sv
// Bench for i2s_rx_ctrl_module: BCK/LRCK table vectors, directed frame sequences and a
// randomized run, all scored against a timing/FIFO model derived from bit-clock arithmetic.
module tb_i2s_rx_ctrl_module;

    localparam int FRAME_RES  = 32;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, en, tready, clr;
    logic [7:0]  div;
    logic [23:0] l_data, r_data;
    logic        bck, lrck, tvalid, ovf, busy;
    logic [47:0] tdata;
`ifdef I2S_RX_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    i2s_rx_ctrl_module dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .div_i      (div),
        .bck_o      (bck),
        .lrck_o     (lrck),
        .left_i     (l_data),
        .right_i    (r_data),
        .tdata_o    (tdata),
        .tvalid_o   (tvalid),
        .tready_i   (tready),
        .ovf_o      (ovf),
        .clr_ovf_i  (clr),
`ifdef I2S_RX_CTRL_DROP_CNT_EN
        .drop_cnt_o (drop_cnt),
`endif
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int data_mode = 0;   // 0 hold, 1 cycle-count pattern, 2 random
    bit rand_ctl  = 0;   // randomize tready/clr every cycle

    // Reference model: time since start, BCK half-period and a queue of pairs.
    bit          m_run, m_stop, m_first;
    int          m_t0, m_h;
    logic [47:0] m_q[$];
    logic        m_ovf;
    logic [15:0] m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic        s_rst, s_en, s_tready, s_clr;
        logic [7:0]  s_div;
        logic [47:0] s_pair;
        int          n, k;
        bit          strobe, fend, pop, push_req, drop;
        logic        e_bck, e_lrck;
        s_rst = rst; s_en = en; s_tready = tready; s_clr = clr; s_div = div;
        s_pair = {l_data, r_data};
        @(posedge clk);
        cyc++;
        if (s_rst) begin
            m_run = 0; m_stop = 0; m_first = 0; m_q.delete(); m_ovf = 0; m_drop = '0;
        end else begin
            strobe = 0; fend = 0;
            if (m_run) begin
                n = cyc - m_t0;
                if (n != 0 && n % (2 * m_h) == 0) begin
                    k = n / (2 * m_h);   // k-th falling BCK edge since start
                    strobe = (k % (2 * FRAME_RES) == 3);
                    fend = m_stop && (k % (2 * FRAME_RES) == 0);
                end
            end
            pop = (m_q.size() > 0) && s_tready;
            push_req = strobe && !m_first;
            if (strobe) m_first = 0;
            drop = push_req && (m_q.size() == FIFO_DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (push_req && !drop) m_q.push_back(s_pair);
            if (drop) m_ovf = 1'b1;
            else if (s_clr) m_ovf = 1'b0;
            if (s_clr) m_drop = drop ? 16'd1 : 16'd0;
            else if (drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            if (!m_run) begin
                if (s_en) begin
                    m_run = 1; m_stop = 0; m_first = 1; m_t0 = cyc; m_h = int'(s_div) + 1;
                end
            end else if (!m_stop) begin
                if (!s_en) m_stop = 1;
            end else if (fend) begin
                m_run = 0; m_stop = 0;
            end
        end
        #1;
        if (m_run) begin
            n = cyc - m_t0;
            e_bck  = ((n / m_h) % 2) == 1;
            e_lrck = ((n / (2 * m_h) / FRAME_RES) % 2) == 1;
        end else begin
            e_bck = 1'b0; e_lrck = 1'b0;
        end
        chk("sb_bck", 64'(bck), 64'(e_bck));
        chk("sb_lrck", 64'(lrck), 64'(e_lrck));
        chk("sb_busy", 64'(busy), 64'(m_run));
        chk("sb_tvalid", 64'(tvalid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) chk("sb_tdata", 64'(tdata), 64'(m_q[0]));
        chk("sb_ovf", 64'(ovf), 64'(m_ovf));
`ifdef I2S_RX_CTRL_DROP_CNT_EN
        chk("sb_drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
        case (data_mode)
            1: begin l_data = 24'(cyc); r_data = ~24'(cyc); end
            2: begin l_data = 24'($urandom); r_data = 24'($urandom); end
            default: ;
        endcase
        if (rand_ctl) begin
            tready = ($urandom_range(0, 3) != 0);
            clr    = ($urandom_range(0, 63) == 0);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] d, output int t0);
        en = 1'b1; div = d;
        step();
        t0 = cyc;
    endtask

    typedef struct {
        logic [7:0] d;
        int         n;
        logic       bck;
        logic       lrck;
    } vec_t;

    vec_t vecs[12];
    int   t0, beats, pairs;

    initial begin
        vecs[0]  = '{8'd1, 0,   1'b0, 1'b0};
        vecs[1]  = '{8'd1, 2,   1'b1, 1'b0};
        vecs[2]  = '{8'd1, 4,   1'b0, 1'b0};
        vecs[3]  = '{8'd1, 127, 1'b1, 1'b0};
        vecs[4]  = '{8'd1, 128, 1'b0, 1'b1};
        vecs[5]  = '{8'd1, 255, 1'b1, 1'b1};
        vecs[6]  = '{8'd1, 256, 1'b0, 1'b0};
        vecs[7]  = '{8'd0, 1,   1'b1, 1'b0};
        vecs[8]  = '{8'd0, 64,  1'b0, 1'b1};
        vecs[9]  = '{8'd3, 3,   1'b0, 1'b0};
        vecs[10] = '{8'd3, 4,   1'b1, 1'b0};
        vecs[11] = '{8'd3, 256, 1'b0, 1'b1};

        rst = 1'b1; en = 1'b0; div = 8'd1; tready = 1'b1; clr = 1'b0;
        l_data = 24'hA5A5A5; r_data = 24'h5A5A5A;

        // Reset state
        step();
        step();
        chk("rst_bck", 64'(bck), 64'd0);
        chk("rst_lrck", 64'(lrck), 64'd0);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // BCK/LRCK phase table
        foreach (vecs[i]) begin
            do_reset();
            start_run(vecs[i].d, t0);
            wait_to(t0 + vecs[i].n);
            chk($sformatf("tbl%0d_bck", i), 64'(bck), 64'(vecs[i].bck));
            chk($sformatf("tbl%0d_lrck", i), 64'(lrck), 64'(vecs[i].lrck));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'd1);
        end

        // Constant ADC data, consumer always ready: first pair skipped, then one beat per frame
        do_reset();
        data_mode = 0; l_data = 24'hA5A5A5; r_data = 24'h5A5A5A; tready = 1'b1;
        start_run(8'd1, t0);
        pairs = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (tvalid) begin
                pairs++;
                chk("t2_tdata", 64'(tdata), 64'h0000_A5A5A5_5A5A5A);
            end
        end
        chk("t2_pairs", 64'(pairs), 64'd3);

        // Stalled consumer over six frames: four pairs held, two dropped
        do_reset();
        data_mode = 1; tready = 1'b0;
        start_run(8'd0, t0);
        wait_to(t0 + 780);
        chk("t3_ovf", 64'(ovf), 64'd1);
        chk("t3_tvalid", 64'(tvalid), 64'd1);
        chk("t3_head", 64'(tdata[47:24]), 64'(24'(t0 + 133)));
`ifdef I2S_RX_CTRL_DROP_CNT_EN
        chk("t3_drop_cnt", 64'(drop_cnt), 64'd2);
`endif
        // Clear in the same cycle as the next drop, then clear alone
        wait_to(t0 + 901);
        clr = 1'b1;
        step();
        chk("t4_ovf_set_wins", 64'(ovf), 64'd1);
`ifdef I2S_RX_CTRL_DROP_CNT_EN
        chk("t4_drop_cnt_one", 64'(drop_cnt), 64'd1);
`endif
        step();
        clr = 1'b0;
        chk("t4_ovf_cleared", 64'(ovf), 64'd0);
`ifdef I2S_RX_CTRL_DROP_CNT_EN
        chk("t4_drop_cnt_zero", 64'(drop_cnt), 64'd0);
`endif
        tready = 1'b1;
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            if (tvalid) begin
                chk("t3_order", 64'(tdata[47:24]), 64'(24'(t0 + 133 + 128 * beats)));
                beats++;
            end
            step();
        end
        chk("t3_beats", 64'(beats), 64'd4);

        // Stop request early in the left half finishes the frame; en pulse in STOP ignored
        do_reset();
        data_mode = 2;
        start_run(8'd1, t0);
        wait_to(t0 + 21);
        en = 1'b0;
        step();
        wait_to(t0 + 100);
        en = 1'b1;
        repeat (3) step();
        en = 1'b0;
        chk("t5_busy_stop", 64'(busy), 64'd1);
        wait_to(t0 + 255);
        chk("t5_busy_last", 64'(busy), 64'd1);
        chk("t5_bck_last", 64'(bck), 64'd1);
        chk("t5_lrck_last", 64'(lrck), 64'd1);
        step();
        chk("t5_busy_idle", 64'(busy), 64'd0);
        chk("t5_bck_idle", 64'(bck), 64'd0);
        chk("t5_lrck_idle", 64'(lrck), 64'd0);
        repeat (5) step();
        chk("t5_stays_idle", 64'(busy), 64'd0);

        // Reset mid right half with two pairs queued and ovf set
        do_reset();
        data_mode = 1; tready = 1'b0;
        start_run(8'd0, t0);
        wait_to(t0 + 780);
        tready = 1'b1;
        step();
        step();
        tready = 1'b0;
        wait_to(t0 + 860);
        chk("t6_pre_lrck", 64'(lrck), 64'd1);
        chk("t6_pre_tvalid", 64'(tvalid), 64'd1);
        chk("t6_pre_ovf", 64'(ovf), 64'd1);
        rst = 1'b1; en = 1'b0;
        step();
        rst = 1'b0;
        chk("t6_tvalid", 64'(tvalid), 64'd0);
        chk("t6_bck", 64'(bck), 64'd0);
        chk("t6_lrck", 64'(lrck), 64'd0);
        chk("t6_ovf", 64'(ovf), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);

        // Randomized runs with random divider, backpressure and clears
        data_mode = 2;
        for (int it = 0; it < 4; it++) begin
            rand_ctl = 1;
            start_run(8'($urandom_range(0, 3)), t0);
            repeat ($urandom_range(200, 1200)) step();
            en = 1'b0;
            for (int i = 0; i < 700 && m_run; i++) step();
            chk("rnd_idle", 64'(busy), 64'd0);
            repeat ($urandom_range(2, 20)) step();
        end
        rand_ctl = 0; clr = 1'b0; tready = 1'b1;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
